// File: rtl/lab1_seq_mult_pkg.sv
// Lab1_pkg: shared widths, product/accumulator types and multiplier FSM states.
// Contents:
//   DW          operand width of the build (2 signed, 8 under USIGNED_OP)
//   CNT_W       width of a counter that can hold the value DW
//   datawidth_t operand type, sumdif_dw_t DW+1-bit accumulator, prod_dtwd_t 2*DW product
//   mult_state_t  IDLE / CALC / DONE states of lab1_seq_mult
package Lab1_pkg;
`ifdef USIGNED_OP
  localparam int DW = 8;
`else
  localparam int DW = 2;
`endif
  localparam int CNT_W = $clog2(DW + 1);
  typedef logic [DW-1:0]   datawidth_t;
  typedef logic [DW:0]     sumdif_dw_t;
  typedef logic [2*DW-1:0] prod_dtwd_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
endpackage

// File: rtl/lab1_booth_step.sv
// lab1_booth_step: one combinational multiply step on {A,Q,q_1} (Booth radix-2, or shift-add under USIGNED_OP).
// Ports:
//   a_i   [DW:0]   accumulator A      a_o   [DW:0]   A after add/sub and shift
//   q_i   [DW-1:0] multiplier Q       q_o   [DW-1:0] Q after shift
//   q_1_i          Booth guard bit    q_1_o          guard after shift
//   m_i   [DW-1:0] multiplicand M
module lab1_booth_step #(
  parameter int DW = 2
) (
  input  logic [DW:0]   a_i,
  input  logic [DW-1:0] q_i,
  input  logic          q_1_i,
  input  logic [DW-1:0] m_i,
  output logic [DW:0]   a_o,
  output logic [DW-1:0] q_o,
  output logic          q_1_o
);
  logic [DW:0] sel;
`ifdef USIGNED_OP
  // A's top bit catches the carry; the shift is logical and the guard bit stays clear.
  assign sel   = q_i[0] ? a_i + {1'b0, m_i} : a_i;
  assign a_o   = {1'b0, sel[DW:1]};
  assign q_1_o = q_1_i;
`else
  // M is sign-extended into DW+1 bits so A-M cannot overflow for the most negative M.
  logic [DW:0] m_ext;
  assign m_ext = {m_i[DW-1], m_i};
  assign sel   = ({q_i[0], q_1_i} == 2'b01) ? a_i + m_ext :
                 ({q_i[0], q_1_i} == 2'b10) ? a_i - m_ext : a_i;
  assign a_o   = {sel[DW], sel[DW:1]};
  assign q_1_o = q_i[0];
`endif
  assign q_o = {sel[0], q_i[DW-1:1]};
endmodule

// File: rtl/lab1_seq_mult.sv
// lab1_seq_mult: iterative multiplier, one step per clock, start/ready in and valid/ack out.
// Ports:
//   clk, rst_n (async, active-low)
//   start_i, a_i, b_i   operand request, taken only while ready_o
//   ready_o             idle and accepting operands
//   valid_o, product_o  finished 2*DW-bit product, held until ack_i
//   ack_i               result consumed, taken only while valid_o
module lab1_seq_mult
  import Lab1_pkg::*;
#(
  parameter int DW = Lab1_pkg::DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [2*DW-1:0] product_o,
  input  logic            ack_i
);
  localparam int CW = $clog2(DW + 1);
  mult_state_t   state, state_nxt;
  logic [DW:0]   a_r, a_n;
  logic [DW-1:0] q_r, q_n, m_r;
  logic          q1_r, q1_n;
  logic [CW-1:0] cnt;
  logic          last;
  lab1_booth_step #(.DW(DW)) u_step (
    .a_i  (a_r),
    .q_i  (q_r),
    .q_1_i(q1_r),
    .m_i  (m_r),
    .a_o  (a_n),
    .q_o  (q_n),
    .q_1_o(q1_n)
  );
  assign last = (cnt == CW'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (start_i ? CALC : IDLE) :
                (state == CALC) ? (last ? DONE : CALC) :
                (state == DONE) ? (ack_i ? IDLE : DONE) : IDLE;
  always_comb begin
    ready_o = (state == IDLE);
    valid_o = (state == DONE);
  end
  // The product register is written only on the final step, so an abort never exposes a partial result.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r       <= '0;
      q_r       <= '0;
      q1_r      <= 1'b0;
      m_r       <= '0;
      cnt       <= '0;
      product_o <= '0;
    end else if (state == IDLE && start_i) begin
      a_r  <= '0;
      q_r  <= b_i;
      q1_r <= 1'b0;
      m_r  <= a_i;
      cnt  <= CW'(DW);
    end else if (state == CALC) begin
      a_r  <= a_n;
      q_r  <= q_n;
      q1_r <= q1_n;
      cnt  <= cnt - CW'(1);
      if (last) product_o <= {a_n[DW-1:0], q_n};
    end
endmodule

// File: tb/tb_lab1_seq_mult.sv
// tb_lab1_seq_mult: randomized and directed checks of DW=2 and DW=8 multipliers against a transaction model.
module tb_lab1_seq_mult;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       st[2];
  logic       ak[2];
  logic [7:0] av[2];
  logic [7:0] bv[2];
  logic       rdy[2];
  logic       vld[2];
  logic [15:0] prd[2];
  logic        r2, v2, r8, v8;
  logic [3:0]  p2;
  logic [15:0] p8;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  lab1_seq_mult #(.DW(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start_i(st[0]), .a_i(av[0][1:0]), .b_i(bv[0][1:0]),
    .ready_o(r2), .valid_o(v2), .product_o(p2), .ack_i(ak[0])
  );
  lab1_seq_mult #(.DW(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start_i(st[1]), .a_i(av[1]), .b_i(bv[1]),
    .ready_o(r8), .valid_o(v8), .product_o(p8), .ack_i(ak[1])
  );
  assign rdy[0] = r2;
  assign vld[0] = v2;
  assign prd[0] = {12'd0, p2};
  assign rdy[1] = r8;
  assign vld[1] = v8;
  assign prd[1] = p8;
  function automatic int dw_of(int i);
    return (i == 0) ? 2 : 8;
  endfunction
  // Reference product: plain integer multiply of the operands read at width dw.
  function automatic logic [15:0] ref_mul(logic [7:0] a, logic [7:0] b, int dw);
    longint sa, sb, m;
    sa = longint'(a) & ((longint'(1) << dw) - 1);
    sb = longint'(b) & ((longint'(1) << dw) - 1);
`ifndef USIGNED_OP
    if (sa >= (longint'(1) << (dw - 1))) sa = sa - (longint'(1) << dw);
    if (sb >= (longint'(1) << (dw - 1))) sb = sb - (longint'(1) << dw);
`endif
    m = (sa * sb) & ((longint'(1) << (2 * dw)) - 1);
    return m[15:0];
  endfunction
  task automatic chk(string nm, int i, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dw=%0d t=%0t got=%h want=%h", nm, dw_of(i), $time, act, exp);
    end
  endtask
  // Transaction model: idle / busy for dw cycles / holding a result.
  int          mm[2];
  int          ml[2];
  logic [15:0] mx[2];
  logic [15:0] mp[2];
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 2; i++)
      if (!rst_n) begin
        mm[i] <= 0;
        ml[i] <= 0;
        mx[i] <= '0;
        mp[i] <= '0;
      end else if (mm[i] == 0) begin
        if (st[i]) begin
          mm[i] <= 1;
          ml[i] <= dw_of(i);
          mx[i] <= ref_mul(av[i], bv[i], dw_of(i));
        end
      end else if (mm[i] == 1) begin
        if (ml[i] == 1) begin
          mm[i] <= 2;
          mp[i] <= mx[i];
        end else ml[i] <= ml[i] - 1;
      end else if (ak[i]) mm[i] <= 0;
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk("ready", i, {15'd0, rdy[i]}, {15'd0, mm[i] == 0});
      chk("valid", i, {15'd0, vld[i]}, {15'd0, mm[i] == 2});
      chk("product", i, prd[i], mp[i]);
    end
  task automatic launch(int i, logic [7:0] a, logic [7:0] b);
    st[i] = 1'b1;
    av[i] = a;
    bv[i] = b;
    @(negedge clk);
    st[i] = 1'b0;
  endtask
  task automatic wait_valid(int i, output int lat);
    lat = 0;
    while (!vld[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!vld[i]) chk("valid_timeout", i, 16'd0, 16'd1);
  endtask
  task automatic ack_now(int i);
    ak[i] = 1'b1;
    @(negedge clk);
    ak[i] = 1'b0;
  endtask
  task automatic op(int i, logic [7:0] a, logic [7:0] b, output int lat, output logic [15:0] p);
    launch(i, a, b);
    wait_valid(i, lat);
    p = prd[i];
    ack_now(i);
  endtask
  initial begin
    int lat;
    int t_prev;
    logic [15:0] p, p0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0;
      ak[i] = 1'b0;
      av[i] = '0;
      bv[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ready", 1, {15'd0, r8}, 16'd1);
    chk("reset_valid", 1, {15'd0, v8}, 16'd0);
    chk("reset_product", 1, p8, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    op(0, 8'h2, 8'h2, lat, p);
    chk("m2x_m2_lat", 0, 16'(lat), 16'd2);
    chk("m2x_m2", 0, p, 16'h0004);
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) begin
        op(0, 8'(x), 8'(y), lat, p);
        chk("sweep", 0, p, ref_mul(8'(x), 8'(y), 2));
      end
    op(0, 8'h1, 8'h2, lat, p);
`ifdef USIGNED_OP
    chk("1x2", 0, p, 16'h0002);
`else
    chk("1x_m2", 0, p, 16'h000E);
`endif
    op(0, 8'h3, 8'h3, lat, p);
`ifdef USIGNED_OP
    chk("3x3", 0, p, 16'h0009);
`else
    chk("m1x_m1", 0, p, 16'h0001);
`endif
    op(1, 8'h80, 8'h80, lat, p);
    chk("80x80_lat", 1, 16'(lat), 16'd8);
    chk("80x80", 1, p, 16'h4000);
    op(1, 8'hFF, 8'hFF, lat, p);
    chk("FFxFF_lat", 1, 16'(lat), 16'd8);
`ifdef USIGNED_OP
    chk("FFxFF", 1, p, 16'hFE01);
`else
    chk("FFxFF", 1, p, 16'h0001);
`endif
    launch(1, 8'd7, 8'd9);
    wait_valid(1, lat);
    p0 = prd[1];
    chk("hold_first", 1, p0, ref_mul(8'd7, 8'd9, 8));
    for (int k = 0; k < 5; k++) begin
      st[1] = 1'b1;
      av[1] = 8'($urandom);
      bv[1] = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 1, {15'd0, v8}, 16'd1);
      chk("hold_product", 1, p8, p0);
    end
    st[1] = 1'b0;
    ack_now(1);
    chk("hold_release_ready", 1, {15'd0, r8}, 16'd1);
    chk("hold_release_product", 1, p8, p0);
    launch(1, 8'd100, 8'd77);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 1, {15'd0, r8}, 16'd1);
    chk("abort_valid", 1, {15'd0, v8}, 16'd0);
    chk("abort_product", 1, p8, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(1, 8'd3, 8'd5, lat, p);
    chk("after_abort", 1, p, 16'd15);
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      launch(1, a, b);
      wait_valid(1, lat);
      chk("b2b_product", 1, p8, ref_mul(a, b, 8));
      if (k > 0) chk("b2b_spacing", 1, 16'(cyc - t_prev), 16'd10);
      t_prev = cyc;
      ack_now(1);
    end
    for (int k = 0; k < 30; k++) begin
      int i;
      logic [7:0] a, b;
      i = int'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      launch(i, a, b);
      wait_valid(i, lat);
      chk("rand_lat", i, 16'(lat), 16'(dw_of(i)));
      chk("rand_product", i, prd[i], ref_mul(a, b, dw_of(i)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack_now(i);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
